// File: rtl/mul_uart_seq_if.sv
// Bus bundle for mul_uart_seq: RX bytes, multiplier operands/product,
// TX valid/ready handshake and status pulses.
interface mul_uart_seq_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  mul_a;
  logic [7:0]  mul_b;
  logic [15:0] mul_p;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        rx_overrun;
  logic        timeout;

  modport master (
    input  rx_data, rx_valid, mul_p, tx_ready,
    output mul_a, mul_b, tx_data, tx_valid,
    output busy, rx_overrun, timeout
  );

  modport slave (
    output rx_data, rx_valid, mul_p, tx_ready,
    input  mul_a, mul_b, tx_data, tx_valid,
    input  busy, rx_overrun, timeout
  );
endinterface

// File: rtl/mul_uart_seq.sv
// UART <-> 8x8 multiplier sequencer: A, B in; product hi, lo out.
// Optional checksum byte after lo when MUL_SEQ_CKSUM_EN is defined.
module mul_uart_seq #(
  parameter int MUL_LAT     = 0,
  parameter int TIMEOUT_CYC = 65535
) (
  input logic           clk,
  input logic           rst,
  mul_uart_seq_if.master bus
);

  localparam logic [15:0] LAT_C = 16'(MUL_LAT);
  localparam logic [15:0] TO_C  = 16'(TIMEOUT_CYC);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_B,
    S_MUL,
    S_SEND_HI,
`ifdef MUL_SEQ_CKSUM_EN
    S_SEND_LO,
    S_SEND_CK
`else
    S_SEND_LO
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [15:0] prod_q, prod_d;
  logic [7:0]  txd_q, txd_d;
  logic        txv_q, txv_d;
  logic        ovr_q, ovr_d;
  logic        to_q, to_d;
  logic        xfer;

  assign xfer = txv_q & bus.tx_ready;

`ifdef MUL_SEQ_CKSUM_EN
  logic [7:0] cks;
  assign cks = a_q ^ b_q ^ prod_q[15:8] ^ prod_q[7:0];
`endif

  // Next-state and datapath updates for the transaction sequence
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    prod_d  = prod_q;
    txd_d   = txd_q;
    txv_d   = txv_q;
    ovr_d   = 1'b0;
    to_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.rx_valid) begin
          a_d     = bus.rx_data;
          cnt_d   = '0;
          state_d = S_WAIT_B;
        end
      end
      S_WAIT_B: begin
        if (bus.rx_valid) begin
          b_d     = bus.rx_data;
          cnt_d   = '0;
          state_d = S_MUL;
        end else if (TIMEOUT_CYC != 0 &&
                     cnt_q == TO_C - 16'd1) begin
          to_d    = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_MUL: begin
        ovr_d = bus.rx_valid;
        if (cnt_q == LAT_C) begin
          prod_d  = bus.mul_p;
          txd_d   = bus.mul_p[15:8];
          txv_d   = 1'b1;
          state_d = S_SEND_HI;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_SEND_HI: begin
        ovr_d = bus.rx_valid;
        if (xfer) begin
          txd_d   = prod_q[7:0];
          state_d = S_SEND_LO;
        end
      end
      S_SEND_LO: begin
        ovr_d = bus.rx_valid;
        if (xfer) begin
`ifdef MUL_SEQ_CKSUM_EN
          txd_d   = cks;
          state_d = S_SEND_CK;
`else
          txv_d   = 1'b0;
          state_d = S_IDLE;
`endif
        end
      end
`ifdef MUL_SEQ_CKSUM_EN
      S_SEND_CK: begin
        ovr_d = bus.rx_valid;
        if (xfer) begin
          txv_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      prod_q  <= '0;
      txd_q   <= '0;
      txv_q   <= 1'b0;
      ovr_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      prod_q  <= prod_d;
      txd_q   <= txd_d;
      txv_q   <= txv_d;
      ovr_q   <= ovr_d;
      to_q    <= to_d;
    end
  end

  assign bus.mul_a      = a_q;
  assign bus.mul_b      = b_q;
  assign bus.tx_data    = txd_q;
  assign bus.tx_valid   = txv_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.rx_overrun = ovr_q;
  assign bus.timeout    = to_q;

endmodule
